laser_range_finder: RTL and testbench

- Parametrised time-of-flight laser ranging controller: fires a laser pulse, counts clock cycles until the echo sensor responds, and reports half the round-trip count as distance.
- Adds to the basic measure loop:
  - configurable counter width and laser pulse length
  - echo timeout with error flag
  - power-of-two multi-shot averaging
  - busy/valid status
- Sits between the user start button / echo sensor and the distance display or readout logic.

---
 rtl/laser_range_finder.sv | 115 +++++++++++
 tb/tb_laser_range_finder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/laser_range_finder.sv
// laser_range_finder: time-of-flight ranging controller.
// Fires a pulse, times the echo, averages 2^LOG2_SHOTS shots, reports half.
module laser_range_finder #(
    parameter int CNT_W      = 16,
    parameter int PULSE_CYC  = 1,
    parameter int TIMEOUT    = 65535,
    parameter int LOG2_SHOTS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             B,
    input  logic             S,
    output logic             L,
    output logic [CNT_W-1:0] D,
    output logic             valid,
    output logic             busy,
    output logic             err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FIRE  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] ACCUM = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam int AW = CNT_W + LOG2_SHOTS;
    localparam int SW = LOG2_SHOTS + 1;

    localparam logic [PW-1:0]  PLAST  = PW'(PULSE_CYC - 1);
    localparam logic [SW-1:0]  SLAST  = SW'((1 << LOG2_SHOTS) - 1);
    localparam logic [CNT_W:0] TO_VAL = (CNT_W+1)'(TIMEOUT);

    logic [2:0]       state;
    logic [PW-1:0]    pcnt;
    logic [CNT_W-1:0] tof;
    logic [CNT_W-1:0] shot;
    logic [SW-1:0]    scnt;
    logic [AW-1:0]    acc;
    logic [CNT_W:0]   tof_inc;
    logic [AW-1:0]    acc_sum;

    // tof+1 is kept one bit wider so the timeout compare never wraps
    assign tof_inc = {1'b0, tof} + (CNT_W+1)'(1);
    assign acc_sum = acc + AW'(shot);

    // status outputs decode straight from the state register
    assign L     = (state == FIRE);
    assign busy  = (state != IDLE);
    assign valid = (state == DONE);

    // measurement sequencer with its counters and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            pcnt  <= '0;
            tof   <= '0;
            shot  <= '0;
            scnt  <= '0;
            acc   <= '0;
            D     <= '0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (B) begin
                        acc   <= '0;
                        scnt  <= '0;
                        pcnt  <= '0;
                        tof   <= '0;
                        err   <= 1'b0;
                        state <= FIRE;
                    end
                end
                FIRE: begin
                    tof <= '0;
                    if (pcnt == PLAST) begin
                        pcnt  <= '0;
                        state <= WAIT;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                WAIT: begin
                    if (S) begin
                        shot  <= tof_inc[CNT_W-1:0];
                        state <= ACCUM;
                    end else if (tof_inc == TO_VAL) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tof <= tof_inc[CNT_W-1:0];
                    end
                end
                ACCUM: begin
                    acc  <= acc_sum;
                    scnt <= scnt + SW'(1);
                    if (scnt == SLAST) begin
                        D     <= CNT_W'(acc_sum >> (LOG2_SHOTS + 1));
                        state <= DONE;
                    end else begin
                        state <= FIRE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_range_finder.sv
// tb_laser_range_finder: randomized bench with a shot-level reference model.
// Two instances: defaults, and a multi-shot / long-pulse / short-timeout one.
module tb_laser_range_finder;

    logic        clk;
    logic        rst;
    logic        b  [2];
    logic        s  [2];
    logic        lo [2];
    logic        vl [2];
    logic        bz [2];
    logic        er [2];
    logic [15:0] d0;
    logic [11:0] d1;

    int checks = 0;
    int errors = 0;
    int dprev  [2];
    int vseen  [2];
    int vexp   [2];

    laser_range_finder u0 (
        .clk(clk), .rst(rst), .B(b[0]), .S(s[0]), .L(lo[0]),
        .D(d0), .valid(vl[0]), .busy(bz[0]), .err(er[0])
    );

    laser_range_finder #(
        .CNT_W(12), .PULSE_CYC(3), .TIMEOUT(30), .LOG2_SHOTS(2)
    ) u1 (
        .clk(clk), .rst(rst), .B(b[1]), .S(s[1]), .L(lo[1]),
        .D(d1), .valid(vl[1]), .busy(bz[1]), .err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vl[0]) vseen[0]++;
        if (vl[1]) vseen[1]++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int dval(input int u);
        return (u == 0) ? int'(d0) : int'(d1);
    endfunction

    // One measurement on unit u; ec[k] is the WAIT cycle of echo k, 0 = none.
    task automatic measure(input int u, input int ec[4]);
        int pc  = (u == 0) ? 1 : 3;
        int to  = (u == 0) ? 65535 : 30;
        int ns  = (u == 0) ? 1 : 4;
        int lg  = (u == 0) ? 0 : 2;
        int sum = 0;
        int lc;
        int w;
        int exp_d;
        bit tout = 0;
        b[u] = 1'b1;
        @(negedge clk);
        b[u] = 1'b0;
        for (int k = 0; k < ns; k++) begin
            lc = 0;
            while (lo[u] && lc < 50) begin
                s[u] = 1'($urandom);
                b[u] = 1'($urandom);
                lc++;
                @(negedge clk);
            end
            check($sformatf("u%0d pulse_len", u), lc, pc);
            w = 1;
            forever begin
                check($sformatf("u%0d wait_busy", u), int'(bz[u]), 1);
                check($sformatf("u%0d wait_valid", u), int'(vl[u]), 0);
                check($sformatf("u%0d wait_L", u), int'(lo[u]), 0);
                s[u] = (w == ec[k]);
                b[u] = 1'($urandom);
                @(negedge clk);
                s[u] = 1'b0;
                b[u] = 1'b0;
                if (w == ec[k]) break;
                if (w == to) begin
                    tout = 1;
                    break;
                end
                w++;
            end
            if (tout) begin
                check($sformatf("u%0d to_err", u), int'(er[u]), 1);
                check($sformatf("u%0d to_busy", u), int'(bz[u]), 0);
                check($sformatf("u%0d to_valid", u), int'(vl[u]), 0);
                check($sformatf("u%0d to_D", u), dval(u), dprev[u]);
                return;
            end
            sum += ec[k];
            check($sformatf("u%0d accum_valid", u), int'(vl[u]), 0);
            check($sformatf("u%0d accum_busy", u), int'(bz[u]), 1);
            @(negedge clk);
        end
        exp_d = sum >> (lg + 1);
        check($sformatf("u%0d done_valid", u), int'(vl[u]), 1);
        check($sformatf("u%0d done_busy", u), int'(bz[u]), 1);
        check($sformatf("u%0d done_D", u), dval(u), exp_d);
        check($sformatf("u%0d done_err", u), int'(er[u]), 0);
        @(negedge clk);
        check($sformatf("u%0d idle_valid", u), int'(vl[u]), 0);
        check($sformatf("u%0d idle_busy", u), int'(bz[u]), 0);
        dprev[u] = exp_d;
        vexp[u]++;
    endtask

    task automatic check_zero(input string tag);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s u%0d L", tag, u), int'(lo[u]), 0);
            check($sformatf("%s u%0d D", tag, u), dval(u), 0);
            check($sformatf("%s u%0d valid", tag, u), int'(vl[u]), 0);
            check($sformatf("%s u%0d busy", tag, u), int'(bz[u]), 0);
            check($sformatf("%s u%0d err", tag, u), int'(er[u]), 0);
        end
    endtask

    initial begin
        int ec[4];
        int u;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b[i] = 1'b0;
            s[i] = 1'b0;
            dprev[i] = 0;
            vexp[i] = 0;
            vseen[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        measure(0, '{10, 0, 0, 0});
        measure(1, '{10, 12, 14, 16});
        measure(1, '{7, 7, 7, 7});
        measure(1, '{0, 0, 0, 0});
        measure(1, '{30, 1, 29, 30});
        measure(1, '{5, 31, 0, 0});

        // reset in the middle of WAIT with D and err non-zero
        measure(1, '{0, 0, 0, 0});
        b[0] = 1'b1;
        @(negedge clk);
        b[0] = 1'b0;
        repeat (4) @(negedge clk);
        check($sformatf("pre_rst L"), int'(lo[0]), 0);
        check($sformatf("pre_rst busy"), int'(bz[0]), 1);
        rst = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b1;
        dprev[0] = 0;
        dprev[1] = 0;
        @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            u = int'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                if (u == 0)
                    ec[k] = int'($urandom_range(1, 60));
                else if ($urandom_range(0, 9) == 0)
                    ec[k] = 0;
                else
                    ec[k] = int'($urandom_range(1, 31));
            end
            measure(u, ec);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        check("u0 valid_count", vseen[0], vexp[0]);
        check("u1 valid_count", vseen[1], vexp[1]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
